// File: rtl/pipe_tracker_pkg.sv
// Shared CPU package: opcode/funct encodings, tracker FSM states and the stage-entry record.
package pipe_tracker_pkg;

  // Widest datapath a stage entry can carry; narrower XLEN values are zero-extended into it.
  localparam int XLEN_MAX = 64;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [2:0] F3_ADD     = 3'b000;
  localparam logic [6:0] F7_ADD     = 7'b0000000;
  localparam logic [6:0] F7_SUB     = 7'b0100000;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0]         instr;
    logic                valid;
    logic                chk;
    logic [XLEN_MAX-1:0] expected;
  } stage_t;

endpackage

// File: rtl/pipe_tracker_if.sv
// Bus bundle between the tracker and its environment; slave is the tracker side.
interface pipe_tracker_if
  import pipe_tracker_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 3,
  parameter int CNT_W = 16
);

  logic [31:0]         instr_i;
  logic                instr_valid_i;
  logic [XLEN-1:0]     rs1_val_i;
  logic [XLEN-1:0]     rs2_val_i;
  logic                stall_i;
  logic                flush_i;
  logic [XLEN-1:0]     alu_result_i;
  logic [DEPTH*32-1:0] stage_instr_o;
  logic [DEPTH-1:0]    stage_valid_o;
  logic                check_valid_o;
  logic                mismatch_o;
  logic [XLEN-1:0]     expected_o;
  logic [CNT_W-1:0]    checked_cnt_o;
  logic [CNT_W-1:0]    err_cnt_o;
  logic [CNT_W-1:0]    cycle_cnt_o;
  logic                done_o;
  state_t              state_o;

  modport slave (
    input  instr_i, instr_valid_i, rs1_val_i, rs2_val_i, stall_i, flush_i, alu_result_i,
    output stage_instr_o, stage_valid_o, check_valid_o, mismatch_o, expected_o,
           checked_cnt_o, err_cnt_o, cycle_cnt_o, done_o, state_o
  );

  modport master (
    output instr_i, instr_valid_i, rs1_val_i, rs2_val_i, stall_i, flush_i, alu_result_i,
    input  stage_instr_o, stage_valid_o, check_valid_o, mismatch_o, expected_o,
           checked_cnt_o, err_cnt_o, cycle_cnt_o, done_o, state_o
  );

endinterface

// File: rtl/tracker_ref_alu.sv
// Reference decode: flags ADD/SUB/ADDI and computes their result modulo 2^XLEN.
module tracker_ref_alu
  import pipe_tracker_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [11:0]     i_hi12,
  input  logic [2:0]      i_funct3,
  input  logic [6:0]      i_opcode,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  output logic            o_chk,
  output logic [XLEN-1:0] o_expected
);

  logic [6:0]      w_funct7;
  logic [XLEN-1:0] w_imm;

  // instr[31:20] doubles as funct7 (top seven bits) and the I-type immediate.
  assign w_funct7 = i_hi12[11:5];
  assign w_imm    = {{(XLEN-12){i_hi12[11]}}, i_hi12};

  always_comb begin
    o_chk      = 1'b0;
    o_expected = '0;
    if (i_opcode == OPC_OP && i_funct3 == F3_ADD && w_funct7 == F7_ADD) begin
      o_chk      = 1'b1;
      o_expected = i_rs1 + i_rs2;
    end else if (i_opcode == OPC_OP && i_funct3 == F3_ADD && w_funct7 == F7_SUB) begin
      o_chk      = 1'b1;
      o_expected = i_rs1 - i_rs2;
    end else if (i_opcode == OPC_OP_IMM && i_funct3 == F3_ADD) begin
      o_chk      = 1'b1;
      o_expected = i_rs1 + w_imm;
    end
  end

endmodule

// File: rtl/pipe_tracker.sv
// Shadow pipeline that follows instructions through DEPTH stages and checks the ALU result
// of each ADD/SUB/ADDI as it leaves CHECK_STAGE; runs MAX_CYCLES, then drains and stops.
module pipe_tracker
  import pipe_tracker_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int DEPTH       = 3,
  parameter int CHECK_STAGE = 1,
  parameter int MAX_CYCLES  = 20,
  parameter int CNT_W       = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  pipe_tracker_if.slave bus
);

  state_t              r_state, w_state_nxt;
  stage_t              w_stage [DEPTH];
  stage_t              w_next  [DEPTH];
  stage_t              w_entry;
  logic                w_chk;
  logic [XLEN-1:0]     w_exp;
  logic                w_advance;
  logic                w_check;
  logic                w_mismatch;
  logic                w_any_next_valid;
  logic                r_check_valid;
  logic                r_mismatch;
  logic [XLEN-1:0]     r_expected;
  logic [CNT_W-1:0]    r_checked;
  logic [CNT_W-1:0]    r_err;
  logic [CNT_W-1:0]    r_cycle;
  logic [DEPTH*32-1:0] w_stage_instr;
  logic [DEPTH-1:0]    w_stage_valid;

  tracker_ref_alu #(.XLEN(XLEN)) u_ref_alu (
    .i_hi12     (bus.instr_i[31:20]),
    .i_funct3   (bus.instr_i[14:12]),
    .i_opcode   (bus.instr_i[6:0]),
    .i_rs1      (bus.rs1_val_i),
    .i_rs2      (bus.rs2_val_i),
    .o_chk      (w_chk),
    .o_expected (w_exp)
  );

  always_comb begin
    w_entry          = '0;
    w_entry.instr    = bus.instr_i;
    w_entry.valid    = bus.instr_valid_i && (r_state == ST_RUN);
    w_entry.chk      = w_chk;
    w_entry.expected = XLEN_MAX'(w_exp);
  end

  // Flush overrides stall: the checked stage and older ones must still move on.
  assign w_advance = (r_state != ST_DONE) && (!bus.stall_i || bus.flush_i);

  always_comb begin
    w_next[0] = w_stage[0];
    if (w_advance) w_next[0] = bus.flush_i ? '0 : w_entry;
    w_any_next_valid = w_next[0].valid;
    for (int k = 1; k < DEPTH; k++) begin
      w_next[k] = w_stage[k];
      if (w_advance) w_next[k] = (bus.flush_i && k <= CHECK_STAGE) ? '0 : w_stage[k-1];
      w_any_next_valid = w_any_next_valid | w_next[k].valid;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    stage_t r_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_q <= '0;
      else         r_q <= w_next[g];
    end
    assign w_stage[g] = r_q;
  end

  assign w_check    = w_advance && w_stage[CHECK_STAGE].valid && w_stage[CHECK_STAGE].chk;
  assign w_mismatch = XLEN_MAX'(bus.alu_result_i) != w_stage[CHECK_STAGE].expected;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:   if (r_cycle + 1'b1 == CNT_W'(MAX_CYCLES)) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (!w_any_next_valid) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_DONE;
      default:  w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state       <= ST_RUN;
      r_check_valid <= 1'b0;
      r_mismatch    <= 1'b0;
      r_expected    <= '0;
      r_checked     <= '0;
      r_err         <= '0;
      r_cycle       <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_check_valid <= w_check;
      r_mismatch    <= w_check && w_mismatch;
      if (w_check) begin
        r_expected <= w_stage[CHECK_STAGE].expected[XLEN-1:0];
        if (r_checked != '1) r_checked <= r_checked + 1'b1;
        if (w_mismatch && r_err != '1) r_err <= r_err + 1'b1;
      end
      if (r_state == ST_RUN) r_cycle <= r_cycle + 1'b1;
    end
  end

  always_comb begin
    w_stage_instr = '0;
    w_stage_valid = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_stage_instr[k*32 +: 32] = w_stage[k].instr;
      w_stage_valid[k]          = w_stage[k].valid;
    end
  end

  assign bus.stage_instr_o = w_stage_instr;
  assign bus.stage_valid_o = w_stage_valid;
  assign bus.check_valid_o = r_check_valid;
  assign bus.mismatch_o    = r_mismatch;
  assign bus.expected_o    = r_expected;
  assign bus.checked_cnt_o = r_checked;
  assign bus.err_cnt_o     = r_err;
  assign bus.cycle_cnt_o   = r_cycle;
  assign bus.done_o        = (r_state == ST_DONE);
  assign bus.state_o       = r_state;

endmodule

// File: tb/tb_pipe_tracker.sv
// Directed bench for pipe_tracker: checking, stall, flush, drain and asynchronous reset.
module tb_pipe_tracker;
  import pipe_tracker_pkg::*;

  localparam logic [31:0] I_ADDI5  = 32'h00500093;
  localparam logic [31:0] I_ADDIM1 = 32'hFFF00093;
  localparam logic [31:0] I_ADD    = 32'h002081B3;
  localparam logic [31:0] I_SUB    = 32'h402081B3;
  localparam logic [31:0] I_LW     = 32'h00002083;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  logic [31:0] exp_q[$];

  pipe_tracker_if #(.XLEN(32), .DEPTH(3), .CNT_W(16)) bus ();

  pipe_tracker #(
    .XLEN(32), .DEPTH(3), .CHECK_STAGE(1), .MAX_CYCLES(20), .CNT_W(16)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [31:0] instr, input logic vld, input logic [31:0] rs1,
                       input logic [31:0] rs2);
    bus.instr_i       = instr;
    bus.instr_valid_i = vld;
    bus.rs1_val_i     = rs1;
    bus.rs2_val_i     = rs2;
  endtask

  task automatic idle();
    drive(32'h0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n            = 1'b0;
    idle();
    bus.stall_i      = 1'b0;
    bus.flush_i      = 1'b0;
    bus.alu_result_i = 32'h0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // scoreboard: a check strobe must carry the oldest queued expected value
  task automatic expect_check(input logic mm);
    logic [31:0] e;
    check_val("check_valid", bus.check_valid_o, 1'b1);
    if (exp_q.size() == 0) begin
      check_val("exp_q_nonempty", 64'(exp_q.size()), 64'd1);
    end else begin
      e = exp_q.pop_front();
      check_val("expected_o", bus.expected_o, e);
      check_val("mismatch_o", bus.mismatch_o, mm);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    idle();
    bus.stall_i      = 1'b0;
    bus.flush_i      = 1'b0;
    bus.alu_result_i = 32'h0;

    // ADDI x1,x0,5 checked as it leaves stage 1
    do_reset();
    check_val("rst_valid", bus.stage_valid_o, 3'b000);
    check_val("rst_chkv", bus.check_valid_o, 1'b0);
    check_val("rst_checked", bus.checked_cnt_o, 16'd0);
    check_val("rst_cycle", bus.cycle_cnt_o, 16'd0);
    check_val("rst_done", bus.done_o, 1'b0);
    check_val("rst_state", bus.state_o, ST_RUN);
    drive(I_ADDI5, 1'b1, 32'd0, 32'd0);
    exp_q.push_back(32'd5);
    step();
    check_val("a_valid_e1", bus.stage_valid_o, 3'b001);
    check_val("a_instr0", bus.stage_instr_o[31:0], I_ADDI5);
    idle();
    bus.alu_result_i = 32'd5;
    step();
    check_val("a_valid_e2", bus.stage_valid_o, 3'b010);
    check_val("a_nochk_e2", bus.check_valid_o, 1'b0);
    step();
    expect_check(1'b0);
    check_val("a_checked", bus.checked_cnt_o, 16'd1);
    step();
    check_val("a_strobe_end", bus.check_valid_o, 1'b0);

    // ADD wrap, ADD mismatch, SUB, negative ADDI, then an unchecked load
    do_reset();
    drive(I_ADD, 1'b1, 32'hFFFFFFFF, 32'd2);
    exp_q.push_back(32'd1);
    step();
    drive(I_ADD, 1'b1, 32'hFFFFFFFF, 32'd2);
    exp_q.push_back(32'd1);
    step();
    bus.alu_result_i = 32'd1;
    drive(I_SUB, 1'b1, 32'd5, 32'd7);
    exp_q.push_back(32'hFFFFFFFE);
    step();
    expect_check(1'b0);
    bus.alu_result_i = 32'd3;
    drive(I_ADDIM1, 1'b1, 32'd10, 32'd0);
    exp_q.push_back(32'd9);
    step();
    expect_check(1'b1);
    check_val("b_err1", bus.err_cnt_o, 16'd1);
    bus.alu_result_i = 32'hFFFFFFFE;
    drive(I_LW, 1'b1, 32'd1, 32'd1);
    step();
    expect_check(1'b0);
    bus.alu_result_i = 32'd9;
    idle();
    step();
    expect_check(1'b0);
    step();
    check_val("b_lw_nochk", bus.check_valid_o, 1'b0);
    check_val("b_checked", bus.checked_cnt_o, 16'd4);
    check_val("b_err", bus.err_cnt_o, 16'd1);

    // stall while the ADDI sits in the check stage
    do_reset();
    drive(I_ADDI5, 1'b1, 32'd0, 32'd0);
    exp_q.push_back(32'd5);
    step();
    idle();
    bus.alu_result_i = 32'd5;
    step();
    bus.stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("c_stall_nochk", bus.check_valid_o, 1'b0);
      check_val("c_stall_valid", bus.stage_valid_o, 3'b010);
      check_val("c_stall_instr1", bus.stage_instr_o[63:32], I_ADDI5);
    end
    check_val("c_cycle", bus.cycle_cnt_o, 16'd5);
    bus.stall_i = 1'b0;
    step();
    expect_check(1'b0);
    step();
    check_val("c_one_check", bus.check_valid_o, 1'b0);
    check_val("c_checked", bus.checked_cnt_o, 16'd1);

    // flush together with stall: older instr advances and is checked, younger one dies
    do_reset();
    drive(I_ADDI5, 1'b1, 32'd0, 32'd0);
    exp_q.push_back(32'd5);
    step();
    drive(I_ADD, 1'b1, 32'd1, 32'd2);
    step();
    drive(I_ADD, 1'b1, 32'd3, 32'd4);
    bus.stall_i      = 1'b1;
    bus.flush_i      = 1'b1;
    bus.alu_result_i = 32'd5;
    step();
    check_val("d_valid", bus.stage_valid_o, 3'b100);
    check_val("d_instr2", bus.stage_instr_o[95:64], I_ADDI5);
    expect_check(1'b0);
    bus.stall_i = 1'b0;
    bus.flush_i = 1'b0;
    idle();
    step();
    check_val("d_killed_nochk", bus.check_valid_o, 1'b0);
    check_val("d_checked", bus.checked_cnt_o, 16'd1);
    check_val("d_empty", bus.stage_valid_o, 3'b000);

    // continuous traffic until drain and done
    do_reset();
    drive(I_LW, 1'b1, 32'd0, 32'd0);
    for (int i = 0; i < 19; i++) step();
    check_val("e_state19", bus.state_o, ST_RUN);
    check_val("e_cycle19", bus.cycle_cnt_o, 16'd19);
    step();
    check_val("e_state20", bus.state_o, ST_DRAIN);
    check_val("e_cycle20", bus.cycle_cnt_o, 16'd20);
    check_val("e_valid20", bus.stage_valid_o, 3'b111);
    check_val("e_done20", bus.done_o, 1'b0);
    step();
    check_val("e_valid21", bus.stage_valid_o, 3'b110);
    step();
    check_val("e_valid22", bus.stage_valid_o, 3'b100);
    check_val("e_done22", bus.done_o, 1'b0);
    step();
    check_val("e_valid23", bus.stage_valid_o, 3'b000);
    check_val("e_done23", bus.done_o, 1'b1);
    check_val("e_state23", bus.state_o, ST_DONE);
    step();
    step();
    check_val("e_cycle_hold", bus.cycle_cnt_o, 16'd20);
    check_val("e_done_hold", bus.done_o, 1'b1);
    check_val("e_frozen", bus.stage_valid_o, 3'b000);

    // asynchronous reset in the middle of a drain
    do_reset();
    drive(I_LW, 1'b1, 32'd0, 32'd0);
    for (int i = 0; i < 21; i++) step();
    check_val("f_pre_state", bus.state_o, ST_DRAIN);
    check_val("f_pre_valid", bus.stage_valid_o, 3'b110);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("f_async_valid", bus.stage_valid_o, 3'b000);
    check_val("f_async_cycle", bus.cycle_cnt_o, 16'd0);
    check_val("f_async_state", bus.state_o, ST_RUN);
    check_val("f_async_instr", bus.stage_instr_o, 96'h0);
    check_val("f_async_done", bus.done_o, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_val("f_resume_cycle", bus.cycle_cnt_o, 16'd1);
    check_val("f_resume_valid", bus.stage_valid_o, 3'b001);

    check_val("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_tracker.md
PIPE_TRACKER -- requirements
Module: pipe_tracker

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter DEPTH, default 3, number of tracked stages (EX, MEM, WB); legal range 2..8.
REQ-003 SHALL have parameter CHECK_STAGE, default 1, stage index whose ALU result is checked; legal range 0..DEPTH-1.
REQ-004 SHALL have parameter MAX_CYCLES, default 20, run length before drain.
REQ-005 SHALL have parameter CNT_W, default 16, counter width.
REQ-006 clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-007 rst_ni  in  1  asynchronous, active-low reset.
REQ-008 instr_i  in  32  instruction entering stage 0.
REQ-009 instr_valid_i  in  1  instr_i is valid.
REQ-010 rs1_val_i, rs2_val_i  in  XLEN  operand values for instr_i.
REQ-011 stall_i  in  1  hold all stages.
REQ-012 flush_i  in  1  kill younger stages.
REQ-013 alu_result_i  in  XLEN  DUT result for the instruction in CHECK_STAGE.
REQ-014 stage_instr_o  out  DEPTH*32  packed stage instructions, stage 0 in LSBs.
REQ-015 stage_valid_o  out  DEPTH  per-stage valid.
REQ-016 check_valid_o, mismatch_o  out  1  one-cycle check strobe and result.
REQ-017 expected_o  out  XLEN  expected value of last check.
REQ-018 checked_cnt_o, err_cnt_o, cycle_cnt_o  out  CNT_W  statistics.
REQ-019 done_o  out  1  run complete.

Function
REQ-020 Advance edge (stall_i=0, state RUN/DRAIN): stage0 <= {instr_i, instr_valid_i (forced 0 in DRAIN)}; stage k <= stage k-1; latency to stage k is k+1 edges.
REQ-021 stall_i=1 SHALL hold all stage contents, valids and expected values.
REQ-022 flush_i=1 SHALL clear valid of stages 0..CHECK_STAGE-1 and load a bubble into stage 0; flush wins over stall; stages >= CHECK_STAGE advance normally.
REQ-023 Expected value computed at stage-0 entry, carried with a chk flag: ADD (opcode 0110011, funct3 000, funct7 0000000) rs1+rs2; SUB (funct7 0100000) rs1-rs2; ADDI (opcode 0010011, funct3 000) rs1+sign-extended instr[31:20]; all modulo 2^XLEN; any other instruction chk=0.
REQ-024 On an advance edge with CHECK_STAGE valid and chk=1: next cycle check_valid_o=1, mismatch_o=(alu_result_i != expected), expected_o=expected; no check during stall (exactly one check per instruction).
REQ-025 checked_cnt_o increments per check, err_cnt_o per mismatch; both saturate at 2^CNT_W-1.
REQ-026 FSM RUN -> DRAIN when cycle_cnt_o reaches MAX_CYCLES; DRAIN -> DONE when all stage valids are 0; DONE is terminal until reset.
REQ-027 cycle_cnt_o increments every edge in RUN, independent of stall; holds in DRAIN/DONE.
REQ-028 In DONE, stages frozen, check_valid_o=0, done_o=1.

Reset
REQ-029 rst_ni low SHALL immediately zero all stages, valids, outputs and counters and enter RUN, including mid-drain or mid-stall.
REQ-030 First advance occurs on the first rising edge after rst_ni deasserts.

Structure
REQ-031 Opcode/funct constants and a stage-entry struct (instr, valid, chk, expected) SHALL live in the shared CPU package.
REQ-032 Decode/expected-value logic SHALL be sub-module tracker_ref_alu; the stage array is a generate-indexed register file.

Verification
REQ-033 ADDI x1,x0,5 (instr 0x00500093), rs1=0, alu_result_i=5 at CHECK_STAGE -> check_valid_o pulse, expected_o=5, mismatch_o=0.
REQ-034 ADD with rs1=0xFFFFFFFF, rs2=2, alu_result_i=1 -> expected_o=1, mismatch_o=0; alu_result_i=3 -> mismatch_o=1, err_cnt_o=1.
REQ-035 ADDI in flight, stall_i high 3 cycles -> stages hold, exactly one check, checked_cnt_o=1.
REQ-036 Two instrs in stages 0 and 1 (CHECK_STAGE=1), flush_i and stall_i together -> stage 0 bubble, stage-1 instr advances and is checked.
REQ-037 MAX_CYCLES=20, continuous valid instrs -> DRAIN at cycle 20, done_o=1 after DEPTH more edges, no new entries accepted.
REQ-038 rst_ni pulsed low during DRAIN -> all outputs 0 asynchronously, RUN resumes from cycle 0.
